median_win_filt: RTL and testbench

MEDIAN_WIN_FILT -- requirements
Module: median_win_filt

---
 rtl/median_filt_pkg.sv | 27 ++
 rtl/median_sort_slot.sv | 34 +++
 rtl/median_win_filt.sv | 168 ++++++++++++++++
 tb/tb_median_win_filt.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/median_filt_pkg.sv
// Shared types and helpers for the sliding-window median filter: FSM state
// encoding, parameter legality checks and the ordered-compare functions.
package median_filt_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic bit win_len_legal(input int n);
        return (n >= 32'sd3) && (n <= 32'sd31) && ((n % 32'sd2) == 32'sd1);
    endfunction

    function automatic bit data_width_legal(input int w);
        return (w >= 32'sd8) && (w <= 32'sd32);
    endfunction

    // Operands arrive already extended to 32 bits by the caller.
    function automatic logic signed_le(input logic [31:0] a, input logic [31:0] b);
        return $signed(a) <= $signed(b);
    endfunction

    function automatic logic unsigned_le(input logic [31:0] a, input logic [31:0] b);
        return a <= b;
    endfunction

endpackage

// File: rtl/median_sort_slot.sv
// One position of the sorted window: picks its next value from its own entry,
// a neighbour, or the incoming sample, using per-position compare flags.
module median_sort_slot #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] prev_val,
    input  logic [DATA_WIDTH-1:0] cur_val,
    input  logic [DATA_WIDTH-1:0] next_val,
    input  logic [DATA_WIDTH-1:0] ins_val,
    input  logic                  gt_prev,
    input  logic                  gt_cur,
    input  logic                  gt_next,
    input  logic                  ge_prev,
    input  logic                  ge_cur,
    output logic [DATA_WIDTH-1:0] slot_next
);

    // gt_* : entry > new sample; ge_* : entry >= evicted value (at/after eviction point).
    // Insert lands at the last slot of the <=new run when eviction is below it,
    // otherwise at the first slot of the >new run.
    always_comb begin
        slot_next = cur_val;
        if ((ge_cur && !gt_cur && gt_next) || (gt_cur && !gt_prev && !ge_prev)) begin
            slot_next = ins_val;
        end else if (gt_prev && !ge_prev) begin
            slot_next = prev_val;
        end else if (ge_cur && !gt_next) begin
            slot_next = next_val;
        end else begin
            slot_next = cur_val;
        end
    end

endmodule

// File: rtl/median_win_filt.sv
// Streaming sliding-window median filter with valid/ready handshakes.
// Optional build macro MEDIAN_WIN_FILT_PREFILL_EN starts from a window of zeros in RUN.
module median_win_filt
    import median_filt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WIN_LEN    = 9,
    parameter int IS_SIGNED  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  win_full
);

    localparam int CNT_W = $clog2(WIN_LEN + 1);
    localparam int MID   = WIN_LEN / 2;

    if (!win_len_legal(WIN_LEN)) begin : g_bad_win_len
        $error("median_win_filt: WIN_LEN must be odd and within 3..31");
    end
    if (!data_width_legal(DATA_WIDTH)) begin : g_bad_data_width
        $error("median_win_filt: DATA_WIDTH must be within 8..32");
    end

`ifdef MEDIAN_WIN_FILT_PREFILL_EN
    localparam state_t           RST_STATE = ST_RUN;
    localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(WIN_LEN);
`else
    localparam state_t           RST_STATE = ST_FILL;
    localparam logic [CNT_W-1:0] RST_CNT   = '0;
`endif

    state_t                  state_r, state_next_s;
    logic [CNT_W-1:0]        count_r, count_next_s;
    logic                    accept_s, produce_s;
    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic [DATA_WIDTH-1:0]   age_r        [WIN_LEN];
    logic [DATA_WIDTH-1:0]   sorted_r     [WIN_LEN];
    logic [DATA_WIDTH-1:0]   sorted_next_s[WIN_LEN];
    logic [DATA_WIDTH-1:0]   val_s        [WIN_LEN+2];
    logic [DATA_WIDTH-1:0]   evict_s;
    logic [WIN_LEN+1:0]      gt_s;
    logic [WIN_LEN:0]        ge_s;

    function automatic logic [31:0] ext32(input logic [DATA_WIDTH-1:0] v);
        if (IS_SIGNED != 0) return 32'($signed(v));
        else                return 32'(v);
    endfunction

    function automatic logic le_cmp(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        if (IS_SIGNED != 0) return signed_le(ext32(a), ext32(b));
        else                return unsigned_le(ext32(a), ext32(b));
    endfunction

    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready && !clear;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign win_full  = (state_r == ST_RUN);
    // During FILL the age register still holds reset zeros, so evicting a zero is exact.
    assign evict_s   = (state_r == ST_RUN) ? age_r[WIN_LEN-1] : '0;

    // Per-position compare flags and neighbour values with fixed boundary sentinels.
    always_comb begin
        gt_s                  = '0;
        ge_s                  = '0;
        gt_s[WIN_LEN+1]       = 1'b1;
        val_s[0]              = '0;
        val_s[WIN_LEN+1]      = '0;
        for (int j = 0; j < WIN_LEN; j++) begin
            gt_s[j+1]  = !le_cmp(sorted_r[j], in_data);
            ge_s[j+1]  = le_cmp(evict_s, sorted_r[j]);
            val_s[j+1] = sorted_r[j];
        end
    end

    for (genvar g = 0; g < WIN_LEN; g++) begin : g_slot
        median_sort_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .prev_val  (val_s[g]),
            .cur_val   (val_s[g+1]),
            .next_val  (val_s[g+2]),
            .ins_val   (in_data),
            .gt_prev   (gt_s[g]),
            .gt_cur    (gt_s[g+1]),
            .gt_next   (gt_s[g+2]),
            .ge_prev   (ge_s[g]),
            .ge_cur    (ge_s[g+1]),
            .slot_next (sorted_next_s[g])
        );
    end

    // FSM next-state, fill counter and output-producing decision.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        produce_s    = 1'b0;
        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    count_next_s = count_r + CNT_W'(1);
                    if (count_r == CNT_W'(WIN_LEN - 1)) begin
                        state_next_s = ST_RUN;
                        produce_s    = 1'b1;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else begin
                    count_next_s = count_r;
                end
            end
            ST_RUN: begin
                produce_s = accept_s;
            end
            default: begin
                state_next_s = ST_FILL;
                count_next_s = '0;
            end
        endcase
    end

    // FSM state and fill counter registers.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_r <= RST_STATE;
            count_r <= RST_CNT;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
        end
    end

    // Window storage and the single output register.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int j = 0; j < WIN_LEN; j++) begin
                age_r[j]    <= '0;
                sorted_r[j] <= '0;
            end
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            if (accept_s) begin
                age_r[0] <= in_data;
                for (int j = 1; j < WIN_LEN; j++) begin
                    age_r[j] <= age_r[j-1];
                end
                sorted_r <= sorted_next_s;
            end
            if (produce_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sorted_next_s[MID];
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_median_win_filt.sv
// Self-checking bench for median_win_filt: vector table, scoreboard queue and
// hand sequences for back-pressure, clear, reset and signedness.
module tb_median_win_filt;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, win_full;
    logic [15:0] out_data;

    logic        v3;
    logic [15:0] d3;
    logic        rdy_s3, ov_s3, wf_s3, rdy_u3, ov_u3, wf_u3;
    logic [15:0] od_s3, od_u3;

    int          n_cmp = 0;
    int          n_err = 0;
    int          hs_cnt = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        bit          clr;
        logic [15:0] din;
        bit          has_out;
        logic [15:0] exp;
        bit          full;
    } vec_t;
    vec_t tbl [0:27];

    always #5 clk = ~clk;

    median_win_filt u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .win_full(win_full)
    );

    median_win_filt #(.DATA_WIDTH(16), .WIN_LEN(3), .IS_SIGNED(1)) u_s3 (
        .clk(clk), .rst(rst), .clear(1'b0), .in_valid(v3), .in_ready(rdy_s3),
        .in_data(d3), .out_valid(ov_s3), .out_ready(1'b1),
        .out_data(od_s3), .win_full(wf_s3)
    );

    median_win_filt #(.DATA_WIDTH(16), .WIN_LEN(3), .IS_SIGNED(0)) u_u3 (
        .clk(clk), .rst(rst), .clear(1'b0), .in_valid(v3), .in_ready(rdy_u3),
        .in_data(d3), .out_valid(ov_u3), .out_ready(1'b1),
        .out_data(od_u3), .win_full(wf_u3)
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Scoreboard: every output handshake pops one expected median.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_data), 32'hDEAD_BEEF);
            end else begin
                check("median", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [15:0] v, input logic [15:0] ex, input bit has_ex);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            if (has_ex) exp_q.push_back(ex);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].clr) do_clear();
            send(tbl[i].din, tbl[i].exp, tbl[i].has_out);
            check($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].has_out));
            check($sformatf("row%0d_win_full", i), 32'(win_full), 32'(tbl[i].full));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 16'd5,     1'b0, 16'd0, 1'b0};
        tbl[1]  = '{1'b0, 16'd2,     1'b0, 16'd0, 1'b0};
        tbl[2]  = '{1'b0, 16'd3,     1'b0, 16'd0, 1'b0};
        tbl[3]  = '{1'b0, 16'd4,     1'b0, 16'd0, 1'b0};
        tbl[4]  = '{1'b0, 16'd1,     1'b0, 16'd0, 1'b0};
        tbl[5]  = '{1'b0, 16'd6,     1'b0, 16'd0, 1'b0};
        tbl[6]  = '{1'b0, 16'd7,     1'b0, 16'd0, 1'b0};
        tbl[7]  = '{1'b0, 16'd15,    1'b0, 16'd0, 1'b0};
        tbl[8]  = '{1'b0, 16'd9,     1'b1, 16'd5, 1'b1};
        tbl[9]  = '{1'b0, 16'd0,     1'b1, 16'd4, 1'b1};
        tbl[10] = '{1'b0, 16'd8,     1'b1, 16'd6, 1'b1};
        tbl[11] = '{1'b0, 16'hFFFB,  1'b1, 16'd6, 1'b1};
        tbl[12] = '{1'b0, 16'd20,    1'b1, 16'd7, 1'b1};
        tbl[13] = '{1'b1, 16'd7,     1'b0, 16'd0, 1'b0};
        for (int i = 14; i <= 20; i++) tbl[i] = '{1'b0, 16'd7, 1'b0, 16'd0, 1'b0};
        tbl[21] = '{1'b0, 16'd7,     1'b1, 16'd7, 1'b1};
        tbl[22] = '{1'b0, 16'd7,     1'b1, 16'd7, 1'b1};
        for (int i = 23; i <= 26; i++) tbl[i] = '{1'b0, 16'd3, 1'b1, 16'd7, 1'b1};
        tbl[27] = '{1'b0, 16'd3,     1'b1, 16'd3, 1'b1};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 16'd0;
        out_ready = 1'b1; v3 = 1'b0; d3 = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

`ifdef MEDIAN_WIN_FILT_PREFILL_EN
        check("rst_win_full", 32'(win_full), 32'd1);
        do_clear();
        check("clr_win_full", 32'(win_full), 32'd1);
        send(16'd8, 16'd0, 1'b1);
        check("prefill_first_valid", 32'(out_valid), 32'd1);
        check("prefill_first_data", 32'(out_data), 32'd0);
`else
        check("rst_win_full", 32'(win_full), 32'd0);

        // WIN_LEN=3 signed vs unsigned ordering of -3, 7, -1.
        @(negedge clk); v3 = 1'b1; d3 = 16'hFFFD;
        @(negedge clk); d3 = 16'd7;
        @(negedge clk); d3 = 16'hFFFF;
        @(posedge clk);
        #1 v3 = 1'b0;
        check("s3_valid", 32'(ov_s3), 32'd1);
        check("s3_data", 32'(od_s3), 32'hFFFF);
        check("u3_valid", 32'(ov_u3), 32'd1);
        check("u3_data", 32'(od_u3), 32'hFFFD);
        check("s3_full", 32'(wf_s3), 32'd1);

        run_rows(0, 12);

        // Back-pressure: output and window hold, in_ready low, then one handshake.
        out_ready = 1'b0;
        begin
            int hs0;
            hs0 = hs_cnt;
            fork
                send(16'd11, 16'd8, 1'b1);
                begin
                    repeat (10) begin
                        @(negedge clk);
                        check("stall_in_ready", 32'(in_ready), 32'd0);
                        check("stall_out_valid", 32'(out_valid), 32'd1);
                        check("stall_out_data", 32'(out_data), 32'd7);
                    end
                    @(posedge clk);
                    #1 out_ready = 1'b1;
                end
            join
            repeat (3) @(posedge clk);
            #1 check("stall_handshakes", 32'(hs_cnt - hs0), 32'd2);
            check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        run_rows(13, 27);

        // clear with a same-cycle sample after 5 fills: sample dropped, refill from zero.
        do_clear();
        for (int k = 1; k <= 5; k++) send(16'(k), 16'd0, 1'b0);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'd99;
        @(posedge clk);
        #1 clear = 1'b0; in_valid = 1'b0;
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_win_full", 32'(win_full), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            send(16'(10 * k), 16'd50, k == 9);
            check($sformatf("refill%0d_valid", k), 32'(out_valid), 32'(k == 9));
        end

        // Reset mid-stream discards a pending output.
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        send(16'd100, 16'd0, 1'b0);
        check("pend_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_win_full", 32'(win_full), 32'd0);
        out_ready = 1'b1;
`endif

        repeat (3) @(posedge clk);
        #1 check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
